// File: rtl/register_file_sb.sv
// Multi-port CPU register file with a pending-write scoreboard.
// The hazard unit reads the busy flags to stall on RAW hazards.
module register_file_sb #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    input  logic [NRD*AW-1:0]     rsel,
    output logic [NRD*DATA_W-1:0] rdat,
    output logic [NRD-1:0]        rbusy,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_sel,
    output logic                  rsv_ok,
    output logic [AW:0]           busy_cnt
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic [NREGS-1:0]  wr_hit;
    logic [DATA_W-1:0] wr_val [NREGS];

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] b);
        logic [AW:0] c;
        c = '0;
        for (int r = 0; r < NREGS; r++)
            c = c + (AW+1)'(b[r]);
        return c;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] sel);
        return (ZERO_R0 != 0) && (sel == '0);
    endfunction

    // Forwarded write data for a read address; the highest-indexed matching port wins.
    function automatic logic [DATA_W-1:0] read_val(input logic [AW-1:0] sel);
        logic [DATA_W-1:0] v;
        v = regs[sel];
        if (BYPASS != 0) begin
            for (int i = 0; i < NWR; i++)
                if (wen[i] && (wsel[i*AW +: AW] == sel))
                    v = wdat[i*DATA_W +: DATA_W];
        end
        if (is_zero_reg(sel))
            v = '0;
        return v;
    endfunction

    // A same-cycle producer retires the pending flag early unless a new reserve lands on it.
    function automatic logic read_busy(input logic [AW-1:0] sel);
        logic b;
        logic hit;
        b   = busy[sel];
        hit = 1'b0;
        for (int i = 0; i < NWR; i++)
            if (wen[i] && (wsel[i*AW +: AW] == sel))
                hit = 1'b1;
        if ((BYPASS != 0) && hit && !(rsv_en && (rsv_sel == sel)))
            b = 1'b0;
        if (is_zero_reg(sel))
            b = 1'b0;
        return b;
    endfunction

    // Per-register write resolution, later ports overriding earlier ones.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int i = 0; i < NWR; i++) begin
                if (wen[i] && (wsel[i*AW +: AW] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wdat[i*DATA_W +: DATA_W];
                end
            end
        end
        if (ZERO_R0 != 0)
            wr_hit[0] = 1'b0;
    end

    // Writes retire pending producers; a same-cycle reserve re-arms the flag.
    always_comb begin
        busy_nxt = busy & ~wr_hit;
        if (rsv_en)
            busy_nxt[rsv_sel] = 1'b1;
        if (ZERO_R0 != 0)
            busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                if (wr_hit[r])
                    regs[r] <= wr_val[r];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= popcount(busy_nxt);
        end
    end

    always_comb begin
        rdat  = '0;
        rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            rdat[j*DATA_W +: DATA_W] = read_val(rsel[j*AW +: AW]);
            rbusy[j]                 = read_busy(rsel[j*AW +: AW]);
        end
    end

    assign rsv_ok = is_zero_reg(rsv_sel) ? 1'b1 : !busy[rsv_sel];

endmodule
